// File: rtl/wb_debug_pkg.sv
// Shared types and constants for the byte-stream driven Wishbone debug initiator.
package wb_debug_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StAddr,
    StWdata,
    StBus,
    StRespData,
    StRespStatus
  } wb_dbg_state_e;

  localparam logic [7:0] CMD_READ_DEFAULT  = 8'h52;
  localparam logic [7:0] CMD_WRITE_DEFAULT = 8'h57;

  localparam logic [7:0] STATUS_OK      = 8'h4B;
  localparam logic [7:0] STATUS_TIMEOUT = 8'h54;

  localparam int unsigned FRAME_ADDR_BYTES = 4;
  localparam int unsigned FRAME_DATA_BYTES = 4;

endpackage

// File: rtl/wb_debug_master.sv
// Host-driven Wishbone initiator: decodes 'R'/'W' frames, runs one classic cycle, replies on TX.
// Define WB_DEBUG_TIMEOUT_EN to abort bus cycles that see no ack within TIMEOUT_CYCLES.
module wb_debug_master
  import wb_debug_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH     = 32,
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned TIMEOUT_CYCLES = 1024,
  parameter logic [7:0]  CMD_READ       = CMD_READ_DEFAULT,
  parameter logic [7:0]  CMD_WRITE      = CMD_WRITE_DEFAULT
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rx_valid_i,
  input  logic [7:0]            rx_data_i,
  output logic                  rx_ready_o,
  output logic                  tx_valid_o,
  output logic [7:0]            tx_data_o,
  input  logic                  tx_ready_i,
  output logic                  cyc_o,
  output logic                  stb_o,
  output logic                  we_o,
  output logic [ADDR_WIDTH-1:0] addr_o,
  output logic [DATA_WIDTH-1:0] data_o,
  input  logic                  ack_i,
  input  logic [DATA_WIDTH-1:0] data_i,
  output logic                  busy_o
);

  wb_dbg_state_e         state_q, state_d;
  logic [1:0]            cnt_q, cnt_d;
  logic                  we_q, we_d;
  logic [31:0]           addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic [7:0]            status_q, status_d;
  logic                  tmo_expired;

`ifdef WB_DEBUG_TIMEOUT_EN
  localparam int unsigned TmoW = $clog2(TIMEOUT_CYCLES) + 1;

  logic [TmoW-1:0] tmo_q, tmo_d;

  // Held at zero outside BUS so it starts from zero on every BUS entry.
  assign tmo_d       = (state_q == StBus && !ack_i) ? tmo_q + TmoW'(1) : '0;
  assign tmo_expired = (state_q == StBus) && !ack_i && (tmo_q == TmoW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      tmo_q <= '0;
    end else begin
      tmo_q <= tmo_d;
    end
  end
`else
  logic unused_tmo;
  assign unused_tmo  = ^TIMEOUT_CYCLES;
  assign tmo_expired = 1'b0;
`endif

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    we_d     = we_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    rdata_d  = rdata_q;
    status_d = status_q;
    unique case (state_q)
      StIdle: begin
        if (rx_valid_i && (rx_data_i == CMD_READ || rx_data_i == CMD_WRITE)) begin
          we_d    = (rx_data_i == CMD_WRITE);
          cnt_d   = '0;
          state_d = StAddr;
        end
      end
      StAddr: begin
        if (rx_valid_i) begin
          addr_d = {rx_data_i, addr_q[31:8]};
          cnt_d  = cnt_q + 2'd1;
          if (cnt_q == 2'(FRAME_ADDR_BYTES - 1)) begin
            cnt_d   = '0;
            state_d = we_q ? StWdata : StBus;
          end
        end
      end
      StWdata: begin
        if (rx_valid_i) begin
          wdata_d = {rx_data_i, wdata_q[DATA_WIDTH-1:8]};
          cnt_d   = cnt_q + 2'd1;
          if (cnt_q == 2'(FRAME_DATA_BYTES - 1)) begin
            cnt_d   = '0;
            state_d = StBus;
          end
        end
      end
      StBus: begin
        // Ack takes priority over a timeout expiring in the same cycle.
        if (ack_i) begin
          rdata_d  = data_i;
          status_d = STATUS_OK;
          cnt_d    = '0;
          state_d  = we_q ? StRespStatus : StRespData;
        end else if (tmo_expired) begin
          rdata_d  = '0;
          status_d = STATUS_TIMEOUT;
          cnt_d    = '0;
          state_d  = we_q ? StRespStatus : StRespData;
        end
      end
      StRespData: begin
        if (tx_ready_i) begin
          cnt_d = cnt_q + 2'd1;
          if (cnt_q == 2'(FRAME_DATA_BYTES - 1)) begin
            cnt_d   = '0;
            state_d = StRespStatus;
          end
        end
      end
      StRespStatus: begin
        if (tx_ready_i) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
      status_q <= STATUS_OK;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      rdata_q  <= rdata_d;
      status_q <= status_d;
    end
  end

  always_comb begin
    rx_ready_o = (state_q == StIdle) || (state_q == StAddr) || (state_q == StWdata);
    cyc_o      = (state_q == StBus);
    stb_o      = (state_q == StBus);
    we_o       = (state_q == StBus) && we_q;
    busy_o     = (state_q != StIdle);
    tx_valid_o = (state_q == StRespData) || (state_q == StRespStatus);
    tx_data_o  = 8'h00;
    if (state_q == StRespData) begin
      tx_data_o = rdata_q[{cnt_q, 3'b000} +: 8];
    end else if (state_q == StRespStatus) begin
      tx_data_o = status_q;
    end
  end

  assign addr_o = ADDR_WIDTH'(addr_q);
  assign data_o = wdata_q;

endmodule

// File: tb/tb_wb_debug_master.sv
// Self-checking bench for wb_debug_master: directed and random frames against a frame-level model.
module tb_wb_debug_master;

  localparam int unsigned TMO = 16;
`ifdef WB_DEBUG_TIMEOUT_EN
  localparam bit TmoEn = 1'b1;
`else
  localparam bit TmoEn = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        rx_valid_i;
  logic [7:0]  rx_data_i;
  logic        rx_ready_o;
  logic        tx_valid_o;
  logic [7:0]  tx_data_o;
  logic        tx_ready_i;
  logic        cyc_o;
  logic        stb_o;
  logic        we_o;
  logic [31:0] addr_o;
  logic [31:0] data_o;
  logic        ack_i;
  logic [31:0] data_i;
  logic        busy_o;

  int checks   = 0;
  int failures = 0;
  logic [7:0] exp_q[$];

  always #5 clk = ~clk;

  wb_debug_master #(
    .ADDR_WIDTH    (32),
    .DATA_WIDTH    (32),
    .TIMEOUT_CYCLES(TMO),
    .CMD_READ      (8'h52),
    .CMD_WRITE     (8'h57)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .rx_valid_i(rx_valid_i),
    .rx_data_i (rx_data_i),
    .rx_ready_o(rx_ready_o),
    .tx_valid_o(tx_valid_o),
    .tx_data_o (tx_data_o),
    .tx_ready_i(tx_ready_i),
    .cyc_o     (cyc_o),
    .stb_o     (stb_o),
    .we_o      (we_o),
    .addr_o    (addr_o),
    .data_o    (data_o),
    .ack_i     (ack_i),
    .data_i    (data_i),
    .busy_o    (busy_o)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    int n;
    n = 0;
    rx_valid_i = 1'b1;
    rx_data_i  = b;
    while (rx_ready_o !== 1'b1 && n < 50) begin
      tick();
      n++;
    end
    if (n >= 50) chk("rx_accept_wait", rx_ready_o, 1);
    tick();
    rx_valid_i = 1'b0;
  endtask

  // Drains exp_q.size() response bytes, optionally stalling the sink every other cycle.
  task automatic collect_tx(input bit toggle);
    int   idx, n;
    bit   rdy, holding;
    logic [7:0] held;
    idx = 0; n = 0; rdy = 1'b0; holding = 1'b0; held = 8'h00;
    while (idx < exp_q.size() && n < 300) begin
      rdy        = toggle ? !rdy : 1'b1;
      tx_ready_i = rdy;
      if (tx_valid_o === 1'b1) begin
        if (holding) chk("tx_hold_stable", tx_data_o, held);
        if (rdy) begin
          chk("tx_byte", tx_data_o, exp_q[idx]);
          idx++;
          holding = 1'b0;
        end else begin
          held    = tx_data_o;
          holding = 1'b1;
        end
      end
      tick();
      n++;
    end
    tx_ready_i = 1'b0;
    chk("tx_count", idx, exp_q.size());
    chk("tx_idle_after", tx_valid_o, 0);
    chk("busy_after", busy_o, 0);
  endtask

  // ack_delay < 0 means the slave never acks.
  task automatic do_txn(input bit is_wr, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [31:0] rdata, input int ack_delay, input bit toggle);
    int k;
    bit timed_out;
    send_byte(is_wr ? 8'h57 : 8'h52);
    for (int i = 0; i < 4; i++) send_byte(8'(addr >> (8 * i)));
    if (is_wr) for (int i = 0; i < 4; i++) send_byte(8'(wdata >> (8 * i)));
    chk("cyc_first", cyc_o, 1);
    chk("stb_first", stb_o, 1);
    chk("we_bus", we_o, is_wr);
    chk("addr_bus", addr_o, addr);
    if (is_wr) chk("wdata_bus", data_o, wdata);
    chk("rx_ready_bus", rx_ready_o, 0);
    k = 0;
    while (cyc_o === 1'b1 && k < int'(TMO) + 10) begin
      ack_i  = (k == ack_delay);
      data_i = ack_i ? rdata : $urandom;
      tick();
      k++;
    end
    ack_i = 1'b0;
    timed_out = TmoEn && (ack_delay < 0 || ack_delay >= int'(TMO));
    chk("bus_cycles", k, timed_out ? int'(TMO) : ack_delay + 1);
    chk("cyc_drop", cyc_o, 0);
    chk("we_drop", we_o, 0);
    exp_q.delete();
    if (!is_wr) for (int i = 0; i < 4; i++) exp_q.push_back(timed_out ? 8'h00 : 8'(rdata >> (8 * i)));
    exp_q.push_back(timed_out ? 8'h54 : 8'h4B);
    collect_tx(toggle);
  endtask

  task automatic send_noise();
    logic [7:0] b;
    b = 8'($urandom);
    if (b == 8'h52 || b == 8'h57) b = b ^ 8'h01;
    send_byte(b);
    chk("noise_ignored", busy_o, 0);
  endtask

  initial begin
    rst = 1'b1; rx_valid_i = 1'b0; rx_data_i = 8'h00; tx_ready_i = 1'b0;
    ack_i = 1'b0; data_i = 32'h0;
    tick();
    tick();
    rst = 1'b0;
    chk("rst_rx_ready", rx_ready_o, 1);
    chk("rst_busy", busy_o, 0);
    chk("rst_cyc", cyc_o, 0);
    chk("rst_stb", stb_o, 0);
    chk("rst_we", we_o, 0);
    chk("rst_addr", addr_o, 0);
    chk("rst_data", data_o, 0);
    chk("rst_tx_valid", tx_valid_o, 0);
    chk("rst_tx_data", tx_data_o, 0);

    // Stray ack in IDLE must not start anything.
    ack_i = 1'b1; data_i = 32'hA5A5A5A5;
    tick();
    tick();
    ack_i = 1'b0;
    chk("idle_ack_busy", busy_o, 0);
    chk("idle_ack_tx", tx_valid_o, 0);

    do_txn(1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 32'h0, 3, 1'b0);
    do_txn(1'b0, 32'h8000_0004, 32'h0, 32'h1234_5678, 1, 1'b0);

    send_byte(8'h00);
    chk("noise_00", busy_o, 0);
    send_byte(8'hFF);
    chk("noise_ff", busy_o, 0);
    do_txn(1'b0, 32'h4000_0100, 32'h0, 32'hCAFE_F00D, 2, 1'b1);
    do_txn(1'b1, 32'h4000_0104, 32'h0BAD_F00D, 32'h0, 0, 1'b1);

    if (TmoEn) begin
      do_txn(1'b0, 32'h0000_0200, 32'h0, 32'h1111_2222, -1, 1'b0);
      do_txn(1'b0, 32'h0000_0204, 32'h0, 32'h3333_4444, int'(TMO) - 1, 1'b0);
      do_txn(1'b1, 32'h0000_0208, 32'h5555_6666, 32'h0, -1, 1'b1);
    end

    // Reset in the middle of a bus cycle.
    send_byte(8'h52);
    for (int i = 0; i < 4; i++) send_byte(8'h20 + 8'(i));
    tick();
    chk("mid_cyc_high", cyc_o, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mid_rst_cyc", cyc_o, 0);
    chk("mid_rst_stb", stb_o, 0);
    chk("mid_rst_busy", busy_o, 0);
    chk("mid_rst_addr", addr_o, 0);
    chk("mid_rst_rx_ready", rx_ready_o, 1);
    tx_ready_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("mid_rst_no_tx", tx_valid_o, 0);
      tick();
    end
    tx_ready_i = 1'b0;

    // Partial write frame dropped by reset; a following read must parse from scratch.
    send_byte(8'h57);
    send_byte(8'h11);
    send_byte(8'h22);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    do_txn(1'b0, 32'h9ABC_DEF0, 32'h0, 32'h7654_3210, 2, 1'b0);

    for (int t = 0; t < 8; t++) begin
      int nz;
      nz = int'($urandom_range(0, 2));
      for (int j = 0; j < nz; j++) send_noise();
      do_txn(1'($urandom), $urandom, $urandom, $urandom, int'($urandom_range(0, 5)),
             1'($urandom));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog observed=running expected=finished");
    $fatal(1, "watchdog expired");
  end

endmodule
